// File: rtl/ex_div_ctrl.sv
// EX-stage sequencer for the multi-cycle divider: stalls the pipeline, holds start,
// returns a one-cycle write-back and serves repeated divisions from a one-entry cache.
module ex_div_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_waddr_o,
  output logic        div_start_o,
  output logic [31:0] div_dividend_o,
  output logic [31:0] div_divisor_o,
  output logic [2:0]  div_op_o,
  output logic [4:0]  div_waddr_o,
  input  logic [31:0] div_result_i,
  input  logic        div_ready_i,
  input  logic        div_busy_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic        accept;
  logic        hit;
  logic        cache_valid;
  logic [2:0]  cache_op;
  logic [31:0] cache_rs1;
  logic [31:0] cache_rs2;
  logic [31:0] cache_result;

  always_comb begin
    accept      = req_i & op_i[2] & ~flush_i;
    hit         = cache_valid & (op_i == cache_op) & (rs1_i == cache_rs1) & (rs2_i == cache_rs2);
    stall_o     = ((state == IDLE) & accept) | (state == BUSY);
    // Start falls with ready so the divider does not relaunch, and with flush so it aborts.
    div_start_o = (state == BUSY) & ~div_ready_i & ~flush_i;
    wb_valid_o  = (state == RESP) & ~flush_i;
  end

  // rstn is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state          <= IDLE;
      wb_data_o      <= '0;
      wb_waddr_o     <= '0;
      div_dividend_o <= '0;
      div_divisor_o  <= '0;
      div_op_o       <= '0;
      div_waddr_o    <= '0;
      cache_valid    <= 1'b0;
      cache_op       <= '0;
      cache_rs1      <= '0;
      cache_rs2      <= '0;
      cache_result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (hit) begin
              wb_data_o  <= cache_result;
              wb_waddr_o <= rd_i;
              state      <= RESP;
            end else begin
              div_dividend_o <= rs1_i;
              div_divisor_o  <= rs2_i;
              div_op_o       <= op_i;
              div_waddr_o    <= rd_i;
              state          <= BUSY;
            end
          end
        end
        BUSY: begin
          if (flush_i) begin
            state <= IDLE;
          end else if (div_ready_i) begin
            wb_data_o    <= div_result_i;
            wb_waddr_o   <= div_waddr_o;
            cache_valid  <= 1'b1;
            cache_op     <= div_op_o;
            cache_rs1    <= div_dividend_o;
            cache_rs2    <= div_divisor_o;
            cache_result <= div_result_i;
            state        <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A fresh divider launch must only happen once the divider has returned to idle.
  a_div_idle_on_launch: assert property (
    @(posedge clk) disable iff (rstn)
    ((state == IDLE) && accept && !hit) |-> !div_busy_i
  );

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Scoreboard bench for ex_div_ctrl with a behavioural divider (2-cycle for zero divisor, 34 otherwise).
module tb_ex_div_ctrl;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        req = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [4:0]  rd = '0;
  logic        flush = 1'b0;
  logic        stall_o, wb_valid_o, div_start_o;
  logic [31:0] wb_data_o, div_dividend_o, div_divisor_o;
  logic [4:0]  wb_waddr_o, div_waddr_o;
  logic [2:0]  div_op_o;
  logic [31:0] div_result = '0;
  logic        div_ready = 1'b0;
  logic        div_busy;
  int          cnt = 0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  waddr;
  } exp_t;
  exp_t sb[$];

  ex_div_ctrl dut (
    .clk(clk), .rstn(rstn), .req_i(req), .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
    .flush_i(flush), .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o),
    .wb_waddr_o(wb_waddr_o), .div_start_o(div_start_o), .div_dividend_o(div_dividend_o),
    .div_divisor_o(div_divisor_o), .div_op_o(div_op_o), .div_waddr_o(div_waddr_o),
    .div_result_i(div_result), .div_ready_i(div_ready), .div_busy_i(div_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      OP_DIV:  ref_div = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      OP_DIVU: ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:  ref_div = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: ref_div = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Divider model: ready pulses after a fixed number of start-high cycles; dropping start aborts it.
  always @(posedge clk) begin
    if (rstn) begin
      cnt <= 0;
      div_ready <= 1'b0;
    end else if (div_start_o && !div_ready) begin
      if (cnt == ((div_divisor_o == 0) ? 1 : 33)) begin
        div_ready  <= 1'b1;
        div_result <= ref_div(div_op_o, div_dividend_o, div_divisor_o);
        cnt <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      div_ready <= 1'b0;
      cnt <= 0;
    end
  end
  assign div_busy = (cnt != 0) | div_ready;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (wb_valid_o) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_wb: got data 0x%08h waddr %0d with nothing expected", wb_data_o, wb_waddr_o);
      end else begin
        e = sb.pop_front();
        if (wb_data_o !== e.data || wb_waddr_o !== e.waddr) begin
          miscompares++;
          $display("FAIL wb_result: got data 0x%08h waddr %0d, expected data 0x%08h waddr %0d",
                   wb_data_o, wb_waddr_o, e.data, e.waddr);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_stall"}, 32'(stall_o), 0);
    check({name, "_wb_valid"}, 32'(wb_valid_o), 0);
    check({name, "_start"}, 32'(div_start_o), 0);
    check({name, "_wb_data"}, wb_data_o, 0);
    check({name, "_wb_waddr"}, 32'(wb_waddr_o), 0);
    check({name, "_div_operands"}, div_dividend_o | div_divisor_o, 0);
    check({name, "_div_op_waddr"}, {24'h0, div_op_o, div_waddr_o}, 0);
  endtask

  // Issue one request, push its expected write-back, and hold req until the RESP cycle.
  task automatic run(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] r, input logic [31:0] exp, input int exp_lat, input logic exp_start);
    int n;
    logic done, saw_start, stall_drop;
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; rd = r; req = 1'b1;
    sb.push_back({exp, r});
    #1 check({name, "_stall_on_req"}, 32'(stall_o), 1);
    n = 0; done = 1'b0; saw_start = 1'b0; stall_drop = 1'b0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      saw_start |= div_start_o;
      if (wb_valid_o) done = 1'b1;
      else stall_drop |= ~stall_o;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: no wb_valid within %0d cycles, expected %0d", name, n, exp_lat);
    end else begin
      check({name, "_latency"}, n, exp_lat);
      check({name, "_stall_in_resp"}, 32'(stall_o), 0);
    end
    check({name, "_start_seen"}, 32'(saw_start), 32'(exp_start));
    check({name, "_stall_held"}, 32'(stall_drop), 0);
    req = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int n, guard;
    logic bad;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b0;

    run("div_miss", OP_DIV, 32'd100, 32'd7, 5'd5, 32'd14, 36, 1'b1);
    run("rem_miss", OP_REM, 32'hFFFF_FF9C, 32'd7, 5'd6, 32'hFFFF_FFFE, 36, 1'b1);
    run("rem_hit", OP_REM, 32'hFFFF_FF9C, 32'd7, 5'd9, 32'hFFFF_FFFE, 1, 1'b0);
    run("divu_zero", OP_DIVU, 32'h1234, 32'd0, 5'd1, 32'hFFFF_FFFF, 4, 1'b1);
    run("remu_zero", OP_REMU, 32'h1234, 32'd0, 5'd2, 32'h0000_1234, 4, 1'b1);

    // Non-division funct3 must be ignored entirely.
    @(negedge clk);
    op = 3'b011; rs1 = 32'd9; rs2 = 32'd3; rd = 5'd8; req = 1'b1;
    bad = 1'b0;
    repeat (3) begin
      #1 bad |= stall_o | div_start_o;
      @(negedge clk);
    end
    check("ignored_op", 32'(bad), 0);
    req = 1'b0;

    // Flush ten cycles into BUSY.
    @(negedge clk);
    op = OP_DIV; rs1 = 32'd500; rs2 = 32'd3; rd = 5'd7; req = 1'b1;
    n = 0; guard = 0;
    while (n < 10 && guard < 40) begin
      @(negedge clk);
      guard++;
      if (div_start_o) n++;
    end
    check("flush_reach_busy", n, 10);
    flush = 1'b1; req = 1'b0;
    #1 check("flush_start_low", 32'(div_start_o), 0);
    check("flush_no_wb", 32'(wb_valid_o), 0);
    @(negedge clk);
    flush = 1'b0;
    #1 check("flush_stall_low", 32'(stall_o), 0);
    check("flush_idle_start", 32'(div_start_o), 0);

    run("div_ovf_miss", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h8000_0000, 36, 1'b1);
    run("div_ovf_hit", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h8000_0000, 1, 1'b0);

    // Reset pulse in the middle of a divider run.
    @(negedge clk);
    op = OP_DIV; rs1 = 32'd1000; rs2 = 32'd10; rd = 5'd4; req = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", 32'(div_start_o), 1);
    rstn = 1'b1; req = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    rstn = 1'b0;
    run("ovf_after_reset", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h8000_0000, 36, 1'b1);

    run("b2b_div", OP_DIV, 32'd20, 32'd3, 5'd10, 32'd6, 36, 1'b1);
    run("b2b_divu", OP_DIVU, 32'd20, 32'd3, 5'd11, 32'd6, 36, 1'b1);

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_div_ctrl.md
# ex_div_ctrl

Sequencing controller between the EX stage and the multi-cycle divider (`ex_mdu`). Accepts DIV/DIVU/REM/REMU requests from EX, holds the divider start line for the whole operation, and stalls the pipeline until the result is ready. Returns a single-cycle write-back pulse, aborts cleanly on pipeline flush, and serves repeated identical divisions from a one-entry result cache without re-running the divider.

## Interface
Parameters
- none; widths come from `RegBus` (32 bit) and `RegAddrBus` (5 bit).

Ports
- clk  in  1  sole clock; all state updates on posedge.
- rstn  in  1  synchronous reset, active-high (asserted level = `RstEnable` = 1'b1). Sampled only on posedge clk.
- req_i  in  1  EX holds a division instruction; stays high until the EX stage advances.
- op_i  in  3  funct3: `INST_DIV`=100, `INST_DIVU`=101, `INST_REM`=110, `INST_REMU`=111.
- rs1_i  in  `RegBus`  dividend.
- rs2_i  in  `RegBus`  divisor.
- rd_i  in  `RegAddrBus`  destination register.
- flush_i  in  1  kill the in-flight division (branch/trap); wins over every other event.
- stall_o  out  1  holds EX/ID/IF; combinational.
- wb_valid_o  out  1  one-cycle write-back strobe.
- wb_data_o  out  `RegBus`  result.
- wb_waddr_o  out  `RegAddrBus`  destination register.
- div_start_o  out  1  divider start; combinational.
- div_dividend_o, div_divisor_o  out  `RegBus`  latched operands.
- div_op_o  out  3  latched op.
- div_waddr_o  out  `RegAddrBus`  latched rd.
- div_result_i  in  `RegBus`  divider result.
- div_ready_i  in  1  divider done, one-cycle pulse.
- div_busy_i  in  1  divider busy; used for assertion checking only.

## Operation
- States: IDLE, BUSY, RESP.
- Accepted request: `req_i & op_i[2] & ~flush_i` in IDLE. Requests with op_i[2]=0 are ignored and get no stall.
- Cache hit: cache valid, and {op, rs1, rs2} equal the stored entry.
- IDLE, accepted request, cache hit: load wb_data_o with the cached result and wb_waddr_o with rd_i, then go to RESP.
- IDLE, accepted request, cache miss: latch op, rs1, rs2 and rd into the div_* registers, then go to BUSY.
- BUSY, flush_i: go to IDLE. Leave the cache untouched and assert no wb_valid.
- BUSY, div_ready_i without flush: capture div_result_i into wb_data_o and the cache, set cache valid, then go to RESP.
- BUSY, neither: stay in BUSY.
- RESP: wb_valid_o=1, stall_o=0. Always return to IDLE next cycle.
- In RESP, req_i is ignored; it still belongs to the retiring instruction. flush_i in RESP suppresses wb_valid_o.
- div_start_o = (state==BUSY) & ~div_ready_i & ~flush_i.
  - Start drops in the same cycle as ready, so the divider (now IDLE) does not relaunch.
  - Start drops in the same cycle as flush, so the divider abandons its calculation.
- stall_o = (IDLE & accepted request) | BUSY.
- Division-by-zero and overflow results come from the divider unchanged: quotient 0xFFFFFFFF, remainder = dividend, 0x80000000/-1 = 0x80000000. Cached like any other result.
- The cache holds one entry. Only the requested result is stored, so DIV then REM on the same operands is a miss.

## Timing
- Reset values:
  - state = IDLE, cache valid = 0.
  - stall_o, wb_valid_o, div_start_o = 0.
  - wb_data_o, wb_waddr_o and all div_* data outputs = 0.
- Cache-hit latency: request in cycle T, wb_valid_o in cycle T+1. stall_o is high only in T.
- Miss latency: request in cycle T, div_start_o high from T+1, wb_valid_o one cycle after div_ready_i.
  - Normal division: about 37 cycles end-to-end.
  - Divisor zero: div_ready_i arrives 2 cycles after start.
- A new request is accepted no earlier than the cycle after RESP. The divider is then guaranteed to be in its IDLE state.
- Reset mid-operation: next cycle is IDLE with start low. The divider, reset on the same line, also idles. The cache is cleared.
- Flush in the same cycle as div_ready_i: flush wins, the result is discarded and the cache is not updated.

## Test plan
- DIV miss, rs1=100, rs2=7, rd=5 -> div_start_o held until ready; wb_valid_o one cycle with wb_data_o=14, wb_waddr_o=5; stall_o high the whole time except RESP.
- REM signed, rs1=-100 (0xFFFFFF9C), rs2=7 -> wb_data_o=0xFFFFFFFE (-2). Repeat the same request -> hit, wb_valid_o on T+1, div_start_o never asserted.
- DIVU by zero, rs1=0x1234, rs2=0 -> wb_data_o=0xFFFFFFFF. REMU by zero -> wb_data_o=0x1234. Both within 4 cycles of request.
- flush_i asserted 10 cycles into BUSY -> div_start_o low that cycle, no wb_valid_o, stall_o low next cycle. An immediately following DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- rstn pulsed mid-BUSY -> all outputs 0 next cycle. The previous hit operands now miss and run the divider.
- Back-to-back DIV (20/3) then DIVU (20/3) -> two separate divider runs (op mismatch), results 6 and 6, exactly one wb_valid_o pulse each.
